// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a JK flip-flop bank to a requested value, checks the feedback and retries.
// Define JK_DRV_TOGGLE_EN to drive changing bits with J=K=1 instead of a set/reset pair.
module jk_bank_driver #(
    parameter int WIDTH = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] tgt_q, diff, j_n, k_n;
    logic [2:0] retry;
    logic accept, match, give_up;
    assign diff = q_fb ^ tgt_q;
`ifdef JK_DRV_TOGGLE_EN
    assign j_n = diff;
    assign k_n = diff;
`else
    assign j_n = diff & tgt_q;
    assign k_n = diff & ~tgt_q;
`endif
    assign tgt_ready = state == IDLE;
    assign accept = tgt_valid && tgt_ready;
    assign match = q_fb == tgt_q;
    assign give_up = retry == 3'(MAX_RETRY);
    always_comb begin
        state_n = state == IDLE   ? (accept ? DRIVE : IDLE) :
                  state == DRIVE  ? SETTLE :
                  state == SETTLE ? CHECK :
                  (match || give_up) ? IDLE : DRIVE;
    end
    // j/k are registered from DRIVE so they are visible only during SETTLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tgt_q <= '0;
            retry <= '0;
            j     <= '0;
            k     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                tgt_q <= tgt;
                retry <= '0;
            end else if (state == CHECK && !match && !give_up) begin
                retry <= retry + 3'd1;
            end
            j    <= state == DRIVE ? j_n : '0;
            k    <= state == DRIVE ? k_n : '0;
            done <= state == CHECK && match;
            err  <= state == CHECK && !match && give_up;
        end
    end
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: JK bank model in the loop, scoreboard of expected outcomes per accepted target.
module tb_jk_bank_driver;
    logic clk = 1'b0, rst = 1'b1, tgt_valid = 1'b0, tgt_ready, done, err;
    logic [3:0] tgt = '0, j, k, q_fb, bank, stuck0 = '0, ld_val = '0;
    logic ld = 1'b0;
    int chk = 0, pass = 0;
    typedef struct packed {logic is_err; logic [3:0] q;} exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    jk_bank_driver dut (
        .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .q_fb(q_fb), .j(j), .k(k), .done(done), .err(err)
    );

    // behavioural JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits
    always @(posedge clk) begin
        if (ld) bank <= ld_val;
        else bank <= ((j & ~bank) | (~k & bank)) & ~stuck0;
    end
    assign q_fb = bank;

    task automatic load_bank(input logic [3:0] v);
        @(negedge clk);
        ld = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic launch(input logic [3:0] t, input logic e_err, input logic [3:0] e_q);
        tgt = t;
        tgt_valid = 1'b1;
        sb.push_back('{is_err: e_err, q: e_q});
    endtask

    task automatic wait_end(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done || err) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tgt_valid = 1'b1;
        tgt = 4'hf;
        ld = 1'b1;
        ld_val = 4'h0;
        repeat (3) @(negedge clk);
        chk++;
        if ({j, k, done, err} !== 10'b0) $display("FAIL reset_outputs: j=%b k=%b done=%b err=%b, need all 0", j, k, done, err);
        else pass++;
        rst = 1'b0;
        tgt_valid = 1'b0;
        ld = 1'b0;
        @(negedge clk);
        chk++;
        if (tgt_ready !== 1'b1) $display("FAIL reset_ready: tgt_ready=%b, need 1", tgt_ready);
        else pass++;
        chk++;
        if ({done, err, j, k} !== 10'b0) $display("FAIL reset_quiet: done=%b err=%b j=%b k=%b, need 0", done, err, j, k);
        else pass++;
    endtask

    task automatic test_set;
        logic [3:0] ej, ek;
`ifdef JK_DRV_TOGGLE_EN
        ej = 4'b1010; ek = 4'b1010;
`else
        ej = 4'b1010; ek = 4'b0000;
`endif
        load_bank(4'b0000);
        @(negedge clk);
        chk++;
        if (tgt_ready !== 1'b1) $display("FAIL set_ready_T: tgt_ready=%b, need 1", tgt_ready);
        else pass++;
        launch(4'b1010, 1'b0, 4'b1010);
        @(negedge clk);
        tgt_valid = 1'b0;
        chk++;
        if (tgt_ready !== 1'b0) $display("FAIL set_ready_T1: tgt_ready=%b, need 0", tgt_ready);
        else pass++;
        @(negedge clk);
        chk++;
        if (j !== ej || k !== ek) $display("FAIL set_jk_T2: j=%b k=%b, need j=%b k=%b", j, k, ej, ek);
        else pass++;
        @(negedge clk);
        chk++;
        if ({j, k, done, err} !== 10'b0) $display("FAIL set_T3: j=%b k=%b done=%b err=%b, need 0", j, k, done, err);
        else pass++;
        @(negedge clk);
        chk++;
        if (done !== 1'b1 || err !== 1'b0 || tgt_ready !== 1'b1)
            $display("FAIL set_done_T4: done=%b err=%b ready=%b, need 1 0 1", done, err, tgt_ready);
        else pass++;
        e = sb.pop_front();
        chk++;
        if (err !== e.is_err || q_fb !== e.q) $display("FAIL set_sb: err=%b q_fb=%b, need err=%b q=%b", err, q_fb, e.is_err, e.q);
        else pass++;
        @(negedge clk);
        chk++;
        if (done !== 1'b0) $display("FAIL set_done_pulse: done=%b at T+5, need 0", done);
        else pass++;
    endtask

    task automatic test_equal;
        logic bad_jk, saw_err;
        int done_at;
        bad_jk = 1'b0;
        saw_err = 1'b0;
        done_at = -1;
        load_bank(4'b0110);
        @(negedge clk);
        launch(4'b0110, 1'b0, 4'b0110);
        if (j !== 4'b0 || k !== 4'b0) bad_jk = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
            if (j !== 4'b0 || k !== 4'b0) bad_jk = 1'b1;
            if (err !== 1'b0) saw_err = 1'b1;
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
        chk++;
        if (bad_jk) $display("FAIL equal_jk: j/k nonzero seen, need 0000 throughout");
        else pass++;
        chk++;
        if (saw_err) $display("FAIL equal_err: err asserted, need never");
        else pass++;
        chk++;
        if (done_at != 4) $display("FAIL equal_done: done at T+%0d, need T+4", done_at);
        else pass++;
        e = sb.pop_front();
        chk++;
        if (q_fb !== e.q) $display("FAIL equal_sb: q_fb=%b, need %b", q_fb, e.q);
        else pass++;
    endtask

    task automatic test_stuck;
        int j0_cnt, err_at;
        logic saw_done;
        j0_cnt = 0;
        err_at = -1;
        saw_done = 1'b0;
        load_bank(4'b0000);
        stuck0 = 4'b0001;
        @(negedge clk);
        launch(4'b0001, 1'b1, 4'b0000);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            tgt_valid = 1'b0;
            if (j[0] === 1'b1) j0_cnt++;
            if (done === 1'b1) saw_done = 1'b1;
            if (err === 1'b1 && err_at < 0) begin
                err_at = i;
                e = sb.pop_front();
                chk++;
                if (err !== e.is_err || q_fb !== e.q) $display("FAIL stuck_sb: err=%b q_fb=%b, need err=%b q=%b", err, q_fb, e.is_err, e.q);
                else pass++;
            end
        end
        stuck0 = 4'b0000;
        chk++;
        if (j0_cnt != 3) $display("FAIL stuck_settles: j[0] high %0d cycles, need 3", j0_cnt);
        else pass++;
        chk++;
        if (err_at != 10) $display("FAIL stuck_err: err at T+%0d, need T+10", err_at);
        else pass++;
        chk++;
        if (saw_done) $display("FAIL stuck_done: done asserted, need never");
        else pass++;
    endtask

    task automatic test_back_to_back;
        logic bad_ready;
        int n;
        bad_ready = 1'b0;
        load_bank(4'b0000);
        @(negedge clk);
        launch(4'b0101, 1'b0, 4'b0101);
        sb.push_back('{is_err: 1'b0, q: 4'b0011});
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tgt = 4'b0011;
            if (tgt_ready !== 1'b0 || done !== 1'b0) bad_ready = 1'b1;
        end
        chk++;
        if (bad_ready) $display("FAIL b2b_ready: tgt_ready or done high during T+1..T+3, need 0");
        else pass++;
        @(negedge clk);
        chk++;
        if (done !== 1'b1 || tgt_ready !== 1'b1) $display("FAIL b2b_done_T4: done=%b ready=%b, need 1 1", done, tgt_ready);
        else pass++;
        e = sb.pop_front();
        chk++;
        if (q_fb !== e.q || err !== e.is_err) $display("FAIL b2b_first_sb: q_fb=%b err=%b, need q=%b err=%b", q_fb, err, e.q, e.is_err);
        else pass++;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk++;
        if (tgt_ready !== 1'b0) $display("FAIL b2b_second_accept: tgt_ready=%b at T+5, need 0", tgt_ready);
        else pass++;
        wait_end(10, n);
        chk++;
        if (n != 3 || done !== 1'b1) $display("FAIL b2b_second_done: end after %0d cycles done=%b, need 3 and 1", n, done);
        else pass++;
        e = sb.pop_front();
        chk++;
        if (q_fb !== e.q || err !== e.is_err) $display("FAIL b2b_second_sb: q_fb=%b err=%b, need q=%b err=%b", q_fb, err, e.q, e.is_err);
        else pass++;
    endtask

    task automatic test_rst_mid;
        logic quiet;
        quiet = 1'b1;
        load_bank(4'b0000);
        @(negedge clk);
        tgt = 4'b1111;
        tgt_valid = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        chk++;
        if (j === 4'b0 && k === 4'b0) $display("FAIL rst_mid_settle: j=%b k=%b, need nonzero in SETTLE", j, k);
        else pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk++;
        if ({j, k, done, err} !== 10'b0) $display("FAIL rst_mid_clear: j=%b k=%b done=%b err=%b, need 0", j, k, done, err);
        else pass++;
        @(negedge clk);
        chk++;
        if (tgt_ready !== 1'b1) $display("FAIL rst_mid_ready: tgt_ready=%b, need 1", tgt_ready);
        else pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || err !== 1'b0) quiet = 1'b0;
        end
        chk++;
        if (!quiet) $display("FAIL rst_mid_pulse: done/err after abort, need none");
        else pass++;
    endtask

    task automatic test_toggle;
        logic [3:0] ej, ek;
        int n;
`ifdef JK_DRV_TOGGLE_EN
        ej = 4'b1111; ek = 4'b1111;
`else
        ej = 4'b0000; ek = 4'b1111;
`endif
        load_bank(4'b1111);
        @(negedge clk);
        launch(4'b0000, 1'b0, 4'b0000);
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        chk++;
        if (j !== ej || k !== ek) $display("FAIL clear_jk_T2: j=%b k=%b, need j=%b k=%b", j, k, ej, ek);
        else pass++;
        wait_end(6, n);
        chk++;
        if (n != 2 || done !== 1'b1 || err !== 1'b0) $display("FAIL clear_done: end %0d cycles after T+2 done=%b err=%b, need 2 1 0", n, done, err);
        else pass++;
        e = sb.pop_front();
        chk++;
        if (q_fb !== e.q) $display("FAIL clear_sb: q_fb=%b, need %b", q_fb, e.q);
        else pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_set;
        test_equal;
        test_stuck;
        test_back_to_back;
        test_rst_mid;
        test_toggle;
        chk++;
        if (sb.size() != 0) $display("FAIL sb_empty: %0d entries left, need 0", sb.size());
        else pass++;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
